// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment glyph constants, symbol types and pattern-to-code decode
package seg_pkg;

    typedef logic [5:0] sym_code_t;

    typedef struct packed {
        logic      unknown;
        sym_code_t code;
    } dec_entry_t;

    localparam sym_code_t SYM_UNKNOWN = 6'd63;
    localparam sym_code_t SYM_BLANK   = 6'd42;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_GRAU  = 8'h63;
    // Codes with no glyph carry bit7 set, which a real pattern is never matched against.
    localparam logic [7:0] SEG_NONE  = 8'h80;
    localparam int         NUM_GLYPHS = 42;

    localparam logic [7:0] SEG_GLYPH [NUM_GLYPHS] = '{
        8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07, 8'h7f, 8'h6f,
        8'h77, 8'h7c, 8'h39, 8'h5e, 8'h79, 8'h71, SEG_NONE, SEG_NONE, SEG_NONE, 8'h58,
        SEG_NONE, SEG_NONE, SEG_NONE, SEG_NONE, 8'h76, 8'h74, 8'h10, SEG_NONE, 8'h1e, 8'h38,
        8'h54, SEG_NONE, 8'h5c, 8'h73, 8'h67, 8'h50, SEG_NONE, 8'h78, 8'h3e, 8'h1c,
        8'h6e, SEG_GRAU
    };

    function automatic dec_entry_t seg_to_code(input logic [7:0] pattern);
        dec_entry_t e;
        logic       hit;
        e.unknown = 1'b1;
        e.code    = SYM_UNKNOWN;
        hit       = 1'b0;
        if (!pattern[7]) begin
            if (pattern == SEG_BLANK) begin
                e.unknown = 1'b0;
                e.code    = SYM_BLANK;
                hit       = 1'b1;
            end
            for (int i = 0; i < NUM_GLYPHS; i++) begin
                if (!hit && SEG_GLYPH[i] == pattern) begin
                    e.unknown = 1'b0;
                    e.code    = sym_code_t'(i);
                    hit       = 1'b1;
                end
            end
        end
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO with occupancy count and zeroed head when empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/seg_pattern_decoder.sv
// rtl/seg_pattern_decoder.sv - stable-pattern filter and 7-seg decode into a FIFO; option SEGDEC_ERRCNT_EN
module seg_pattern_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 4
) (
    input  logic                     clk_2,
    input  logic                     reset,
    input  logic [7:0]               seg_in,
    output logic [5:0]               out_code,
    output logic                     out_unknown,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
`ifdef SEGDEC_ERRCNT_EN
    ,
    output logic [7:0]               err_count
`endif
);
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    logic [7:0]       seg_q;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             push_req;
    logic             pop;
    logic             full;
    logic             empty;
    dec_entry_t       dec;
    dec_entry_t       head;

    assign dec      = seg_to_code(seg_q);
    assign push_req = (seg_in == seg_q) && (int'(cnt) >= STABLE_CYCLES - 1) && armed;
    assign pop      = out_valid && out_ready;

    // armed is cleared after the one push so a held pattern is reported only once.
    always_ff @(posedge clk_2) begin
        if (!reset) begin
            seg_q <= 8'h00;
            cnt   <= '0;
            armed <= 1'b0;
        end else if (seg_in != seg_q) begin
            seg_q <= seg_in;
            cnt   <= '0;
            armed <= 1'b1;
        end else if (int'(cnt) < STABLE_CYCLES - 1) begin
            cnt   <= cnt + 1'b1;
        end else if (armed) begin
            armed <= 1'b0;
        end
    end

    always_ff @(posedge clk_2) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push_req && full && !pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef SEGDEC_ERRCNT_EN
    always_ff @(posedge clk_2) begin
        if (!reset) begin
            err_count <= 8'd0;
        end else if (push_req && dec.unknown && err_count != 8'hff) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

    sync_fifo #(
        .WIDTH ($bits(dec_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk_2),
        .resetn (reset),
        .push   (push_req),
        .pop    (pop),
        .wdata  (dec),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

    assign out_valid   = !empty;
    assign out_code    = head.code;
    assign out_unknown = head.unknown;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// tb/tb_seg_pattern_decoder.sv - directed self-checking bench for seg_pattern_decoder
module tb_seg_pattern_decoder;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [7:0] seg_in;
    logic       out_ready;
    logic [5:0] out_code;
    logic       out_unknown;
    logic       out_valid;
    logic [2:0] fifo_count;
    logic       overflow;
`ifdef SEGDEC_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_2 = ~clk_2;

    seg_pattern_decoder #(.STABLE_CYCLES(4), .DEPTH(4)) dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .seg_in      (seg_in),
        .out_code    (out_code),
        .out_unknown (out_unknown),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
`ifdef SEGDEC_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; seg_in = 8'h3f; out_ready = 1'b0;
        tick(2);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", out_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0d exp 0", overflow); end
        checks++; if (out_code !== 6'd0) begin errors++; $display("FAIL reset_code got %0d exp 0", out_code); end
        reset = 1'b1;
        tick(4);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_early_push got %0d exp 0", out_valid); end
        tick(1);
        checks++; if (out_valid !== 1'b1 || out_code !== 6'd0 || out_unknown !== 1'b0)
            begin errors++; $display("FAIL release_push got v=%0d c=%0d u=%0d exp v=1 c=0 u=0", out_valid, out_code, out_unknown); end
        tick(6);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL held_once got %0d exp 1", fifo_count); end
        out_ready = 1'b1; tick(1); out_ready = 1'b0;
        checks++; if (fifo_count !== 3'd0 || out_code !== 6'd0) begin errors++; $display("FAIL reset_drain got n=%0d c=%0d exp n=0 c=0", fifo_count, out_code); end
    endtask

    task automatic test_single_pop;
        seg_in = 8'h5b; out_ready = 1'b1;
        tick(4);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_early got %0d exp 0", out_valid); end
        tick(1);
        checks++; if (out_valid !== 1'b1 || out_code !== 6'd2) begin errors++; $display("FAIL pop_head got v=%0d c=%0d exp v=1 c=2", out_valid, out_code); end
        tick(1);
        checks++; if (out_valid !== 1'b0 || out_code !== 6'd0) begin errors++; $display("FAIL pop_empty got v=%0d c=%0d exp v=0 c=0", out_valid, out_code); end
        out_ready = 1'b0;
    endtask

    task automatic test_glitch;
        seg_in = 8'h6d; tick(2);
        seg_in = 8'h00; tick(1);
        seg_in = 8'h6d; tick(4);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL glitch_restart got %0d exp 0", out_valid); end
        tick(3);
        checks++; if (fifo_count !== 3'd1 || out_code !== 6'd5) begin errors++; $display("FAIL glitch_entry got n=%0d c=%0d exp n=1 c=5", fifo_count, out_code); end
        out_ready = 1'b1; tick(1); out_ready = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL glitch_drain got %0d exp 0", fifo_count); end
    endtask

    task automatic test_unknown;
        seg_in = 8'hff; tick(5);
        checks++; if (out_valid !== 1'b1 || out_code !== 6'd63 || out_unknown !== 1'b1)
            begin errors++; $display("FAIL unknown_entry got v=%0d c=%0d u=%0d exp v=1 c=63 u=1", out_valid, out_code, out_unknown); end
`ifdef SEGDEC_ERRCNT_EN
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL err_count got %0d exp 1", err_count); end
`endif
        out_ready = 1'b1; tick(1); out_ready = 1'b0;
        checks++; if (out_unknown !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL unknown_drain got v=%0d u=%0d exp 0 0", out_valid, out_unknown); end
    endtask

    task automatic test_overflow;
        logic [7:0] pats [6];
        pats = '{8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seg_in = pats[i]; tick(5);
        end
        checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL fill got n=%0d ovf=%0d exp n=4 ovf=0", fifo_count, overflow); end
        for (int i = 4; i < 6; i++) begin
            seg_in = pats[i]; tick(5);
        end
        checks++; if (fifo_count !== 3'd4 || overflow !== 1'b1) begin errors++; $display("FAIL overflow got n=%0d ovf=%0d exp n=4 ovf=1", fifo_count, overflow); end
        checks++; if (out_code !== 6'd1) begin errors++; $display("FAIL overflow_head got %0d exp 1", out_code); end
    endtask

    task automatic test_full_push_pop;
        logic [5:0] exp_codes [4];
        exp_codes = '{6'd2, 6'd3, 6'd4, 6'd41};
        seg_in = 8'h63; tick(4);
        out_ready = 1'b1; tick(1); out_ready = 1'b0;
        checks++; if (fifo_count !== 3'd4 || overflow !== 1'b1) begin errors++; $display("FAIL full_pushpop got n=%0d ovf=%0d exp n=4 ovf=1", fifo_count, overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_code !== exp_codes[i])
                begin errors++; $display("FAIL drain_%0d got v=%0d c=%0d exp v=1 c=%0d", i, out_valid, out_code, exp_codes[i]); end
            tick(1);
        end
        out_ready = 1'b0;
        checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got n=%0d v=%0d exp 0 0", fifo_count, out_valid); end
    endtask

    task automatic test_reset_clears;
        seg_in = 8'h07; tick(5);
        checks++; if (fifo_count !== 3'd1 || out_code !== 6'd7) begin errors++; $display("FAIL pre_reset got n=%0d c=%0d exp n=1 c=7", fifo_count, out_code); end
        reset = 1'b0; out_ready = 1'b1; tick(1); reset = 1'b1; out_ready = 1'b0;
        checks++; if (fifo_count !== 3'd0 || overflow !== 1'b0 || out_code !== 6'd0)
            begin errors++; $display("FAIL reset_clear got n=%0d ovf=%0d c=%0d exp 0 0 0", fifo_count, overflow, out_code); end
`ifdef SEGDEC_ERRCNT_EN
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt got %0d exp 0", err_count); end
`endif
        seg_in = 8'h00; tick(6);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL blank_after_reset got %0d exp 0", out_valid); end
    endtask

    initial begin
        test_reset;
        test_single_pop;
        test_glitch;
        test_unknown;
        test_overflow;
        test_full_push_pop;
        test_reset_clears;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
